// File: rtl/jzjpcc_hazard_controller.sv
// Pipeline hazard controller: a 4-state FSM plus inputs drive combinational stall/flush controls and a memory watchdog.
// Define JZJPCC_HAZARD_PERF_COUNTERS_EN to add the stallCycles/flushEvents performance counters.
module jzjpcc_hazard_controller #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  rs1Addr_decode,
  input  logic [4:0]  rs2Addr_decode,
  input  logic        usesRs1_decode,
  input  logic        usesRs2_decode,
  input  logic [4:0]  rdAddr_execute,
  input  logic        rdWriteEnable_execute,
  input  logic        memRead_execute,
  input  logic        pcCTWriteEnable,
  input  logic        memBusy,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        flush_decode,
  output logic        flush_execute,
`ifdef JZJPCC_HAZARD_PERF_COUNTERS_EN
  output logic [31:0] stallCycles,
  output logic [31:0] flushEvents,
`endif
  output logic        memTimeout
);

  localparam logic [1:0]  RUN           = 2'd0;
  localparam logic [1:0]  LOAD_STALL    = 2'd1;
  localparam logic [1:0]  CT_FLUSH      = 2'd2;
  localparam logic [1:0]  MEM_WAIT      = 2'd3;
  localparam logic [15:0] TIMEOUT_LIMIT = MEM_TIMEOUT[15:0];
  localparam logic [15:0] WAIT_MAX      = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic        ct_pending_q, ct_pending_d;
  logic [15:0] wait_count_q, wait_count_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic rs1_hit, rs2_hit, load_use;
  // One-hot intent: hold the whole pipe, flush for a CT, the CT fetch-latency tail, or a load-use bubble.
  logic hold_all, ct_flush, ct_tail, load_bubble;

  assign rs1_hit  = usesRs1_decode & (rs1Addr_decode == rdAddr_execute);
  assign rs2_hit  = usesRs2_decode & (rs2Addr_decode == rdAddr_execute);
  assign load_use = memRead_execute & rdWriteEnable_execute & (rdAddr_execute != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_d      = state_q;
    ct_pending_d = ct_pending_q;
    hold_all     = 1'b0;
    ct_flush     = 1'b0;
    ct_tail      = 1'b0;
    load_bubble  = 1'b0;
    unique case (state_q)
      RUN, LOAD_STALL: begin
        if (memBusy) begin
          // A CT resolving under a memory hold is remembered, not dropped.
          hold_all     = 1'b1;
          ct_pending_d = ct_pending_q | pcCTWriteEnable;
          state_d      = MEM_WAIT;
        end else if (pcCTWriteEnable) begin
          ct_flush = 1'b1;
          state_d  = CT_FLUSH;
        end else if ((state_q == RUN) && load_use) begin
          load_bubble = 1'b1;
          state_d     = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      CT_FLUSH: begin
        if (memBusy) begin
          hold_all     = 1'b1;
          ct_pending_d = 1'b1;
          state_d      = MEM_WAIT;
        end else if (pcCTWriteEnable) begin
          ct_flush = 1'b1;
          state_d  = CT_FLUSH;
        end else begin
          ct_tail = 1'b1;
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (memBusy) begin
          hold_all     = 1'b1;
          ct_pending_d = ct_pending_q | pcCTWriteEnable;
        end else if (pcCTWriteEnable) begin
          // A fresh CT on the release cycle supersedes the pending one.
          ct_flush     = 1'b1;
          ct_pending_d = 1'b0;
          state_d      = CT_FLUSH;
        end else if (ct_pending_q) begin
          ct_pending_d = 1'b0;
          state_d      = CT_FLUSH;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    wait_count_d = '0;
    if ((state_q == MEM_WAIT) && memBusy) begin
      wait_count_d = (wait_count_q == WAIT_MAX) ? wait_count_q : wait_count_q + 16'd1;
    end
    mem_timeout_d = mem_timeout_q | (wait_count_d == TIMEOUT_LIMIT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= RUN;
      ct_pending_q  <= 1'b0;
      wait_count_q  <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ct_pending_q  <= ct_pending_d;
      wait_count_q  <= wait_count_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Gating with reset_n keeps the controls quiet while reset is held, whatever the inputs do.
  assign stall_fetch   = reset_n & (hold_all | load_bubble);
  assign stall_decode  = reset_n & (hold_all | load_bubble);
  assign stall_execute = reset_n & hold_all;
  assign flush_decode  = reset_n & (ct_flush | ct_tail);
  assign flush_execute = reset_n & (ct_flush | load_bubble);
  assign memTimeout    = mem_timeout_q;

`ifdef JZJPCC_HAZARD_PERF_COUNTERS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_fetch | stall_decode | stall_execute};
    flush_events_d = flush_events_q + {31'd0, state_d == CT_FLUSH};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign stallCycles = stall_cycles_q;
  assign flushEvents = flush_events_q;
`endif

endmodule

// File: doc/jzjpcc_hazard_controller.md
JZJPCC_HAZARD_CONTROLLER -- requirements
Module: jzjpcc_hazard_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the number of consecutive memBusy cycles after which memTimeout sets (range 1..65535).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports rs1Addr_decode, rs2Addr_decode  input  5 each  decode-stage source register addresses.
REQ-005 SHALL have ports usesRs1_decode, usesRs2_decode  input  1 each  decode instruction reads rs1 / rs2.
REQ-006 SHALL have ports rdAddr_execute  input  5, rdWriteEnable_execute  input  1, memRead_execute  input  1  execute-stage destination and load flag.
REQ-007 SHALL have port pcCTWriteEnable  input  1  control transfer resolved in execute this cycle.
REQ-008 SHALL have port memBusy  input  1  data memory is not ready; the pipeline must hold.
REQ-009 SHALL have outputs stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute  1 each  pipeline register hold and bubble controls.
REQ-010 SHALL have output memTimeout  1  sticky memory watchdog error flag.

Function
REQ-011 SHALL implement the states RUN, LOAD_STALL, CT_FLUSH and MEM_WAIT in a registered state machine; all stall and flush outputs SHALL be combinational from the state and the current inputs.
REQ-012 SHALL detect loadUse = memRead_execute & rdWriteEnable_execute & (rdAddr_execute!=0) & ((usesRs1_decode & rs1Addr_decode==rdAddr_execute) | (usesRs2_decode & rs2Addr_decode==rdAddr_execute)).
REQ-013 SHALL apply event priority memBusy > pcCTWriteEnable > loadUse in every state that evaluates events.
REQ-014 In RUN with memBusy: SHALL assert all three stalls with no flushes and SHALL go to MEM_WAIT.
REQ-015 In RUN with pcCTWriteEnable: SHALL assert flush_decode and flush_execute with no stalls and SHALL go to CT_FLUSH.
REQ-016 In RUN with loadUse: SHALL assert stall_fetch, stall_decode and flush_execute (one bubble) and SHALL go to LOAD_STALL.
REQ-017 In LOAD_STALL: SHALL not evaluate loadUse, SHALL apply memBusy and pcCTWriteEnable as in RUN, and otherwise SHALL return to RUN with all outputs 0; the total load-use penalty SHALL be exactly one cycle.
REQ-018 In CT_FLUSH: SHALL assert flush_decode for exactly one cycle to cover the synchronous fetch latency, then return to RUN; memBusy SHALL take priority, setting ctPending and going to MEM_WAIT.
REQ-019 In MEM_WAIT: SHALL assert all three stalls while memBusy=1; a pcCTWriteEnable arriving during the wait SHALL set ctPending.
REQ-020 On leaving MEM_WAIT (memBusy=0): if ctPending=1, SHALL clear it and go to CT_FLUSH; otherwise SHALL go to RUN.
REQ-021 SHALL increment a 16-bit waitCount each MEM_WAIT cycle, saturating, and SHALL clear it when the state is left.
REQ-022 SHALL set memTimeout when waitCount reaches MEM_TIMEOUT; memTimeout SHALL stay set until reset.
REQ-023 SHALL never assert a stall and a flush to the same pipeline register in the same cycle.

Reset
REQ-024 While reset_n=0 at a clock edge: state SHALL become RUN, ctPending 0, waitCount 0, memTimeout 0, and all stall/flush outputs SHALL read 0 from the next cycle, including when reset is applied mid-stall or mid-wait.

Configuration
REQ-025 With JZJPCC_HAZARD_PERF_COUNTERS_EN defined: SHALL add outputs stallCycles (32 bits, counts cycles with any stall asserted) and flushEvents (32 bits, counts entries to CT_FLUSH); both SHALL wrap and reset to 0.
REQ-026 Without JZJPCC_HAZARD_PERF_COUNTERS_EN: these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Load x5 in execute, decode add x6,x5,x7 -> one cycle of stall_fetch=stall_decode=flush_execute=1, then all outputs 0; rd=x0 load -> no stall.
REQ-028 pcCTWriteEnable pulse in RUN -> cycle 1 flush_decode=flush_execute=1, cycle 2 flush_decode=1 only, cycle 3 all 0.
REQ-029 memBusy held 4 cycles with pcCTWriteEnable in wait cycle 2 -> 4 stall cycles, then the CT_FLUSH one-cycle flush_decode, then RUN.
REQ-030 MEM_TIMEOUT=3, memBusy held 5 cycles -> memTimeout sets on reaching waitCount 3 and stays 1 after memBusy drops, until reset_n=0.
REQ-031 reset_n=0 during MEM_WAIT with ctPending=1 -> next cycle all outputs 0, no CT_FLUSH after release; with the macro defined, stallCycles/flushEvents read 0.
